demux_event_counter: RTL and testbench

Four-channel event capture stage that sits directly downstream of the 1-to-4 demultiplexer and consumes its 4-bit OUT bus. Each demux output line is one channel. The block counts events per channel into saturating counters and flags overflow. Counts are read out through a four-phase request/acknowledge port, so a controller can see how often the demux routed an active input to each destination.

---
 rtl/demux_event_counter.sv | 113 +++++++++++
 tb/tb_demux_event_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_event_counter.sv
// Four-channel saturating event counter behind a 1-to-4 demux, with a four-phase read port.
// Define DEMUX_EVENT_EDGE_EN to count rising edges; otherwise every high cycle counts.
module demux_event_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [3:0]       ovf,
  output logic             any
);

`ifdef DEMUX_EVENT_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_WAIT  = 2'd2
  } rd_state_t;

  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W:0]   cnt_inc [4];
  logic [3:0]       in_prev;
  logic [3:0]       evt;
  rd_state_t        rd_state;

  // Returns {saturated, next}; a saturated counter holds its value.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return {1'b1, c};
    end
    return {1'b0, c + CNT_W'(1)};
  endfunction

  assign evt = EDGE_MODE ? (in & ~in_prev) : in;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_inc[i] = sat_inc(cnt[i]);
    end
  end

  // Stage: per-channel counters and sticky overflow; clear beats a same-edge event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_prev <= '0;
      ovf     <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      in_prev <= in;
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (evt[i]) begin
          cnt[i] <= cnt_inc[i][CNT_W-1:0];
          if (cnt_inc[i][CNT_W]) begin
            ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign any = (cnt[0] != '0) || (cnt[1] != '0) || (cnt[2] != '0) || (cnt[3] != '0);

  // Stage: read handshake; the snapshot takes the pre-edge count of the selected channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= S_IDLE;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (rd_state)
        S_IDLE: begin
          rd_ack <= 1'b0;
          if (rd_req) begin
            rd_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          rd_data  <= cnt[rd_sel];
          rd_ack   <= 1'b1;
          rd_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!rd_req) begin
            rd_ack   <= 1'b0;
            rd_state <= S_IDLE;
          end
        end
        default: begin
          rd_ack   <= 1'b0;
          rd_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_event_counter.sv
// Directed bench for demux_event_counter; expectations follow DEMUX_EVENT_EDGE_EN if defined.
module tb_demux_event_counter;

`ifdef DEMUX_EVENT_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in;
  logic             clr;
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic [3:0]       ovf;
  logic             any;

  int nchecks = 0;
  int nerr    = 0;

  demux_event_counter #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .clr     (clr),
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .ovf     (ovf),
    .any     (any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full handshake on channel sel with in held at 0.
  task automatic read_chk(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    rd_req = 1'b1;
    tick();
    chk({tag, "_ack_latch"}, 32'(rd_ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(rd_ack), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), exp);
    rd_req = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(rd_ack), 32'd0);
  endtask

  task automatic pulse(input logic [3:0] v, input int n);
    repeat (n) begin
      in = v;
      tick();
      in = 4'b0000;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in = 4'b1111; clr = 1'b0; rd_req = 1'b1; rd_sel = 2'd0;
    #2;
    chk("rst_ack",  32'(rd_ack),  32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_ovf",  32'(ovf),     32'd0);
    chk("rst_any",  32'(any),     32'd0);
    tick(2);
    chk("rst_hold_any", 32'(any),    32'd0);
    chk("rst_hold_ack", 32'(rd_ack), 32'd0);

    // Release with a request pending: ack after the second edge.
    in = 4'b0000;
    rst = 1'b0;
    tick();
    chk("rel_ack_e1", 32'(rd_ack), 32'd0);
    tick();
    chk("rel_ack_e2",  32'(rd_ack),  32'd1);
    chk("rel_data_e2", 32'(rd_data), 32'd0);
    rd_req = 1'b0;
    tick();
    chk("rel_ack_drop", 32'(rd_ack), 32'd0);

    // Hold channel 0 high for three cycles.
    in = 4'b0001;
    tick(3);
    in = 4'b0000;
    tick();
    chk("hold_any", 32'(any), 32'd1);
    read_chk(2'd0, EDGE ? 32'd1 : 32'd3, "hold_ch0");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("hold_clr_any", 32'(any), 32'd0);

    // Demux walk: A=1, SEL=0..3, five cycles each.
    for (int s = 0; s < 4; s++) begin
      in = 4'b0001 << s;
      tick(5);
    end
    in = 4'b0000;
    tick();
    chk("walk_any", 32'(any), 32'd1);
    chk("walk_ovf", 32'(ovf), 32'd0);
    read_chk(2'd0, EDGE ? 32'd1 : 32'd5, "walk_ch0");
    read_chk(2'd1, EDGE ? 32'd1 : 32'd5, "walk_ch1");
    read_chk(2'd2, EDGE ? 32'd1 : 32'd5, "walk_ch2");
    read_chk(2'd3, EDGE ? 32'd1 : 32'd5, "walk_ch3");
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Saturation on channel 2: 255 reaches the top, the 256th sets overflow.
    pulse(4'b0100, 255);
    chk("sat_ovf_pre", 32'(ovf), 32'd0);
    read_chk(2'd2, 32'd255, "sat_ch2_max");
    pulse(4'b0100, 5);
    chk("sat_ovf", 32'(ovf), 32'b0100);
    read_chk(2'd2, 32'd255, "sat_ch2_held");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sat_clr_ovf", 32'(ovf), 32'd0);
    chk("sat_clr_any", 32'(any), 32'd0);
    read_chk(2'd2, 32'd0, "sat_clr_ch2");

    // Handshake: channel-1 event lands on the latch edge; later sel changes ignored.
    pulse(4'b0010, 2);
    rd_sel = 2'd1;
    rd_req = 1'b1;
    tick();
    chk("hs_ack_latch", 32'(rd_ack), 32'd0);
    in = 4'b0010;
    tick();
    in = 4'b0000;
    chk("hs_ack",  32'(rd_ack),  32'd1);
    chk("hs_data", 32'(rd_data), 32'd2);
    rd_sel = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hs_hold_ack",  32'(rd_ack),  32'd1);
      chk("hs_hold_data", 32'(rd_data), 32'd2);
    end
    rd_req = 1'b0;
    tick();
    chk("hs_ack_drop", 32'(rd_ack),  32'd0);
    chk("hs_data_kept", 32'(rd_data), 32'd2);
    read_chk(2'd1, 32'd3, "hs_ch1_after");

    // Clear colliding with a channel-3 event.
    pulse(4'b1000, 1);
    chk("col_any_pre", 32'(any), 32'd1);
    in = 4'b1000;
    clr = 1'b1;
    tick();
    in = 4'b0000;
    clr = 1'b0;
    tick();
    chk("col_any", 32'(any), 32'd0);
    read_chk(2'd3, 32'd0, "col_ch3");

    // Reset in WAIT aborts the read at once.
    pulse(4'b0001, 1);
    rd_sel = 2'd0;
    rd_req = 1'b1;
    tick(2);
    chk("abort_pre_ack",  32'(rd_ack),  32'd1);
    chk("abort_pre_data", 32'(rd_data), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ack",  32'(rd_ack),  32'd0);
    chk("abort_data", 32'(rd_data), 32'd0);
    chk("abort_any",  32'(any),     32'd0);
    rd_req = 1'b0;
    tick();
    rst = 1'b0;
    tick(2);
    chk("abort_idle_ack", 32'(rd_ack), 32'd0);
    read_chk(2'd0, 32'd0, "abort_ch0");

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
